aes_cipher: RTL and testbench

Iterative AES forward cipher (FIPS-197 encryption) for AES-128/192/256, the encrypt-direction counterpart of the inverse-cipher datapath. It consumes round keys in forward order, round 0 first, from the key-expansion block's per-cycle round-key stream, one round per accepted key. The state is held in a single 128-bit register. A start/busy/done handshake frames each block.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_round.sv | 42 ++++
 rtl/aes_cipher.sv | 89 ++++++++
 tb/tb_aes_cipher.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box, GF(2^8) doubling, key-length modes,
// round counts and the cipher FSM state encoding.
package aes_pkg;

    localparam logic [1:0] MODE_128  = 2'd0;
    localparam logic [1:0] MODE_192  = 2'd1;
    localparam logic [1:0] MODE_256  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FINAL = 2'd3
    } aes_state_e;

    // Forward S-box, entry 0 in the leftmost byte
    localparam logic [0:2047] SBOX_BITS = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_BITS[{b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_192: return 4'd12;
            MODE_256: return 4'd14;
            default:  return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/aes_round.sv
// One forward AES round: SubBytes, ShiftRows, MixColumns (skipped in the
// final round) and AddRoundKey. Purely combinational.
module aes_round
    import aes_pkg::*;
(
    input  logic [0:127] state,
    input  logic [0:127] round_key,
    input  logic         final_round,
    output logic [0:127] next_state
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            sb[i] = sbox(state[8*i +: 8]);
        end
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            mc[4*c]     = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                          ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                          ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                          ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1]
                          ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        next_state = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            next_state[8*i +: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[8*i +: 8];
        end
    end

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-128/192/256 encryption core. Consumes one externally supplied
// round key per accepted cycle, round 0 first; start/busy/done frame a block.
module aes_cipher
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [0:127] data_in,
    input  logic [0:127] round_key,
    input  logic         key_valid,
    output logic         key_ack,
    output logic [3:0]   round,
    output logic         busy,
    output logic         done,
    output logic [0:127] data_out
);

    aes_state_e   fsm;
    logic [0:127] state;
    logic [1:0]   block_mode;
    logic [0:127] round_out;
    logic         final_round;

    assign final_round = (fsm == ST_FINAL);
    assign key_ack     = busy & key_valid;

    aes_round u_round (
        .state       (state),
        .round_key   (round_key),
        .final_round (final_round),
        .next_state  (round_out)
    );

    // Block sequencing, state register, round counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm        <= ST_IDLE;
            state      <= '0;
            block_mode <= MODE_128;
            round      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
        end else begin
            done <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (start && mode != MODE_RSVD) begin
                        state      <= data_in;
                        block_mode <= mode;
                        round      <= '0;
                        busy       <= 1'b1;
                        fsm        <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (key_valid) begin
                        state <= state ^ round_key;
                        round <= 4'd1;
                        fsm   <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (key_valid) begin
                        state <= round_out;
                        round <= round + 4'd1;
                        // key Nr-1 is the last full round; key Nr goes to FINAL
                        if (round == nr_of(block_mode) - 4'd1) begin
                            fsm <= ST_FINAL;
                        end
                    end
                end
                ST_FINAL: begin
                    if (key_valid) begin
                        data_out <= round_out;
                        round    <= nr_of(block_mode);
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        fsm      <= ST_IDLE;
                    end
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher.sv
// Directed bench for aes_cipher: the bench builds its own S-box and key
// schedule, serves round keys on key_ack, and scores ciphertexts from a queue.
module tb_aes_cipher;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   mode;
    logic [0:127] data_in;
    logic [0:127] round_key;
    logic         key_valid;
    logic         key_ack;
    logic [3:0]   round;
    logic         busy;
    logic         done;
    logic [0:127] data_out;

    aes_cipher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .data_in   (data_in),
        .round_key (round_key),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .round     (round),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out)
    );

    localparam logic [0:127] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:255] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [0:255] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [0:255] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:255] K_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    int           checks = 0;
    int           fails  = 0;
    logic [7:0]   ref_sbox [256];
    logic [0:127] rk [15];
    logic [0:127] exp_q [$];
    int           kidx;
    int           cur_nr;
    bit           active;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box = affine transform of the multiplicative inverse
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            ref_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic int nr_for(input logic [1:0] m);
        return (m == 2'd0) ? 10 : (m == 2'd1) ? 12 : 14;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
    endfunction

    task automatic expand(input logic [1:0] m, input logic [0:255] key);
        int nk, nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        nr = nr_for(m);
        nk = nr - 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One clock: check key_ack against the model mid-cycle, then advance
    task automatic tick();
        bit ack_exp;
        @(negedge clk);
        ack_exp = active && key_valid;
        chk("key_ack", key_ack, ack_exp);
        @(posedge clk);
        #1;
        if (ack_exp) kidx++;
    endtask

    task automatic start_block(input logic [1:0] m, input logic [0:127] pt, input logic [0:255] key,
                               input logic [0:127] ct, input string name);
        expand(m, key);
        kidx      = 0;
        cur_nr    = nr_for(m);
        mode      = m;
        data_in   = pt;
        start     = 1'b1;
        key_valid = 1'b1;
        round_key = rk[0];
        exp_q.push_back(ct);
        tick();
        start  = 1'b0;
        active = 1'b1;
        chk({name, " busy_after_start"}, busy, 1);
        chk({name, " done_after_start"}, done, 0);
        chk({name, " round_after_start"}, round, 0);
    endtask

    task automatic wait_done(input bit stall3, input bit poke, input string name);
        int stalls = 0;
        int lat    = 0;
        bit seen   = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            key_valid = !(stall3 && (c % 3 == 2));
            if (!key_valid) stalls++;
            round_key = rk[(kidx > 14) ? 14 : kidx];
            start = poke && (c == 4);
            if (start) begin
                mode    = 2'd0;
                data_in = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
            lat++;
            start = 1'b0;
            chk({name, " round"}, round, (kidx > cur_nr) ? cur_nr : kidx);
            chk({name, " done"}, done, kidx == cur_nr + 1);
            if (done === 1'b1) begin
                seen   = 1;
                active = 1'b0;
                chk({name, " busy_at_done"}, busy, 0);
                chk({name, " latency"}, lat, cur_nr + 1 + stalls);
                chk({name, " scoreboard_nonempty"}, exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk({name, " data_out"}, data_out, exp_q.pop_front());
            end
        end
        chk({name, " done_seen"}, seen, 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; key_valid = 1'b1; mode = 2'd0;
        data_in = '0; round_key = '0; active = 1'b0; kidx = 0; cur_nr = 10;
        build_sbox();
        tick();
        tick();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset round", round, 0);
        chk("reset data_out", data_out, 0);
        rst_n = 1'b1;
        key_valid = 1'b0;
        tick();

        start_block(2'd0, PT, K128, CT128, "aes128");
        wait_done(1'b0, 1'b0, "aes128");

        start_block(2'd1, PT, K192, CT192, "aes192");
        wait_done(1'b0, 1'b0, "aes192");

        start_block(2'd2, PT, K256, CT256, "aes256_stall");
        wait_done(1'b1, 1'b0, "aes256_stall");

        start_block(2'd0, PT_B, K_B, CT_B, "b2b_1");
        wait_done(1'b0, 1'b1, "b2b_1");
        start_block(2'd0, PT, K128, CT128, "b2b_2");
        wait_done(1'b0, 1'b0, "b2b_2");

        start_block(2'd0, PT_B, K_B, CT_B, "midreset");
        key_valid = 1'b1;
        for (int c = 0; c < 20 && kidx < 5; c++) begin
            round_key = rk[kidx];
            tick();
        end
        chk("midreset round_before", round, 5);
        rst_n = 1'b0;
        tick();
        active = 1'b0;
        exp_q.delete();
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset data_out", data_out, 0);
        chk("midreset round", round, 0);
        rst_n = 1'b1;
        key_valid = 1'b0;
        tick();
        chk("midreset no_done", done, 0);

        start_block(2'd0, PT, K128, CT128, "after_reset");
        wait_done(1'b0, 1'b0, "after_reset");

        mode = 2'd3; start = 1'b1; key_valid = 1'b1; data_in = PT_B;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("reserved busy", busy, 0);
            chk("reserved done", done, 0);
        end
        start = 1'b0;
        chk("reserved data_out_held", data_out, CT128);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
